// File: rtl/sentry_pkg.sv
// Sentry shared parameters header and package: bus widths, requester ID type
// and the round-robin pick helper used by the hash scheduler.
`ifndef SENTRY_PARAMS_SVH
`define SENTRY_PARAMS_SVH
`define LINE_WIDTH    128
`define ADDRCNT_WIDTH 64
`define SMAC_WIDTH    64
`endif

package sentry_pkg;

   // Widest requester population the ID type has to cover.
   localparam int MAX_NREQ = 8;

   typedef logic [2:0] req_id_t;

   typedef struct packed {
      logic    found;
      req_id_t idx;
   } rr_pick_t;

   // First eligible index at or after 'start', wrapping modulo n.
   // Offsets are walked high to low so the smallest offset is written last.
   function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] elig,
                                        input req_id_t             start,
                                        input int                  n);
      rr_pick_t   res;
      int         idx;
      logic [2:0] idx3;
      res.found = 1'b0;
      res.idx   = 3'd0;
      for (int off = MAX_NREQ - 1; off >= 0; off--) begin
         if (off < n) begin
            idx  = (int'(start) + off) % n;
            idx3 = 3'(idx);
            if (elig[idx3]) begin
               res.found = 1'b1;
               res.idx   = idx3;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sentry_id_fifo.sv
// In-order FIFO of requester IDs for jobs that are in flight in the engine.
module sentry_id_fifo
   import sentry_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  req_id_t                din,
   input  logic                   pop,
   output req_id_t                dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   req_id_t       mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Qualify push/pop against the current occupancy.
   always_comb begin
      do_push_s = push && (count_r != FULL_CNT);
      do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
   end

   // ID storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally on the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (count_r == FULL_CNT);
   assign empty = (count_r == {(AW+1){1'b0}});
   assign count = count_r;

endmodule

// File: rtl/sentry_hash_sched.sv
// Round-robin scheduler sharing one pipelined hash engine between requesters;
// results are routed back to their owners in issue order via an ID FIFO.
module sentry_hash_sched
   import sentry_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int MAX_OUTST = 8
)
(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NREQ-1:0]                      cfg_enable,
   input  logic [NREQ-1:0]                      req_valid,
   output logic [NREQ-1:0]                      req_ready,
   input  logic [NREQ-1:0][`LINE_WIDTH-1:0]     req_message,
   input  logic [NREQ-1:0][`ADDRCNT_WIDTH-1:0]  req_addrcnt,
   output logic                                 eng_req,
   output logic [`LINE_WIDTH-1:0]               eng_message,
   output logic [`ADDRCNT_WIDTH-1:0]            eng_addrcnt,
   input  logic                                 eng_ready,
   input  logic [`SMAC_WIDTH-1:0]               eng_digest,
   output logic                                 rsp_valid,
   output logic [$clog2(NREQ)-1:0]              rsp_id,
   output logic [`SMAC_WIDTH-1:0]               rsp_digest,
   output logic [$clog2(MAX_OUTST):0]           outstanding,
   output logic                                 err_orphan
);

   localparam int IDW = $clog2(NREQ);

   logic [MAX_NREQ-1:0]        elig_s;
   rr_pick_t                   pick_s;
   logic [IDW-1:0]             gnt_s;
   logic [NREQ-1:0]            ready_s;
   logic                       fire_s;
   logic                       retire_s;
   logic                       orphan_s;
   logic                       fifo_full_s;
   logic                       fifo_empty_s;
   req_id_t                    head_s;

   req_id_t                    rr_ptr_r;
   logic                       eng_req_r;
   logic [`LINE_WIDTH-1:0]     eng_message_r;
   logic [`ADDRCNT_WIDTH-1:0]  eng_addrcnt_r;
   logic                       rsp_valid_r;
   logic [IDW-1:0]             rsp_id_r;
   logic [`SMAC_WIDTH-1:0]     rsp_digest_r;
   logic                       err_orphan_r;

   // Arbitrate among eligible requesters; the FIFO is filled at accept time,
   // so its full flag already accounts for the job sitting in the issue stage.
   always_comb begin
      elig_s           = {MAX_NREQ{1'b0}};
      elig_s[NREQ-1:0] = req_valid & cfg_enable;
      pick_s           = rr_pick(elig_s, rr_ptr_r, NREQ);
      gnt_s            = pick_s.idx[IDW-1:0];
      ready_s          = {NREQ{1'b0}};
      if (rst_n && pick_s.found && !fifo_full_s) begin
         ready_s[gnt_s] = 1'b1;
      end else begin
         ready_s = {NREQ{1'b0}};
      end
      fire_s   = |ready_s;
      retire_s = eng_ready && !fifo_empty_s;
      orphan_s = eng_ready && fifo_empty_s;
   end

   assign req_ready = ready_s;

   // Round-robin pointer: search restarts one past the last grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= 3'd0;
      end else if (fire_s) begin
         rr_ptr_r <= (pick_s.idx == req_id_t'(NREQ - 1)) ? 3'd0 : pick_s.idx + 3'd1;
      end
   end

   // Issue stage: register the granted line and pulse the engine one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_req_r     <= 1'b0;
         eng_message_r <= {`LINE_WIDTH{1'b0}};
         eng_addrcnt_r <= {`ADDRCNT_WIDTH{1'b0}};
      end else begin
         eng_req_r <= fire_s;
         if (fire_s) begin
            eng_message_r <= req_message[gnt_s];
            eng_addrcnt_r <= req_addrcnt[gnt_s];
         end
      end
   end

   // Response stage: pair each engine result with the oldest in-flight owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= {IDW{1'b0}};
         rsp_digest_r <= {`SMAC_WIDTH{1'b0}};
      end else begin
         rsp_valid_r <= retire_s;
         if (retire_s) begin
            rsp_id_r     <= head_s[IDW-1:0];
            rsp_digest_r <= eng_digest;
         end
      end
   end

   // Sticky error: a result arrived with nothing in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_orphan_r <= 1'b0;
      end else if (orphan_s) begin
         err_orphan_r <= 1'b1;
      end
   end

   sentry_id_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fire_s),
      .din   (pick_s.idx),
      .pop   (retire_s),
      .dout  (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (outstanding)
   );

   assign eng_req     = eng_req_r;
   assign eng_message = eng_message_r;
   assign eng_addrcnt = eng_addrcnt_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_id      = rsp_id_r;
   assign rsp_digest  = rsp_digest_r;
   assign err_orphan  = err_orphan_r;

endmodule

// File: tb/tb_sentry_hash_sched.sv
// Randomized bench for sentry_hash_sched against a queue-based reference model.
module tb_sentry_hash_sched;

   localparam int NREQ = 4;
   localparam int MAXO = 8;
   localparam int LW   = `LINE_WIDTH;
   localparam int AW   = `ADDRCNT_WIDTH;
   localparam int SW   = `SMAC_WIDTH;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b1;
   logic [NREQ-1:0]            cfg_enable = '0;
   logic [NREQ-1:0]            req_valid = '0;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0][LW-1:0]    req_message = '0;
   logic [NREQ-1:0][AW-1:0]    req_addrcnt = '0;
   logic                       eng_req;
   logic [LW-1:0]              eng_message;
   logic [AW-1:0]              eng_addrcnt;
   logic                       eng_ready = 1'b0;
   logic [SW-1:0]              eng_digest = '0;
   logic                       rsp_valid;
   logic [1:0]                 rsp_id;
   logic [SW-1:0]              rsp_digest;
   logic [3:0]                 outstanding;
   logic                       err_orphan;

   sentry_hash_sched #(.NREQ(NREQ), .MAX_OUTST(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .req_valid(req_valid),
      .req_ready(req_ready), .req_message(req_message), .req_addrcnt(req_addrcnt),
      .eng_req(eng_req), .eng_message(eng_message), .eng_addrcnt(eng_addrcnt),
      .eng_ready(eng_ready), .eng_digest(eng_digest), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_digest(rsp_digest), .outstanding(outstanding),
      .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // reference model: in-flight owner list, next search start, sticky error
   int          m_q[$];
   int          m_ptr = 0;
   logic        m_orphan = 1'b0;
   logic        exp_eng_req = 1'b0;
   logic [LW-1:0] exp_msg = '0;
   logic [AW-1:0] exp_ac = '0;
   logic        exp_rsp_v = 1'b0;
   int          exp_rsp_id = 0;
   logic [SW-1:0] exp_dig = '0;

   // engine stand-in and stimulus knobs
   int          eng_cnt = 0;
   int          v_mode = 0;
   logic [3:0]  en_val = 4'h0;
   int          rdy_pct = 0;
   bit          orph_ok = 1'b0;
   int          dut_g2 = 0;
   int          rsp2_cnt = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] r;
      for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic step();
      int         g;
      logic [3:0] vmask;
      @(posedge clk); #1;
      if (eng_req) eng_cnt++;
      check_val("eng_req", eng_req, exp_eng_req);
      if (exp_eng_req) begin
         check_val("eng_message", eng_message, exp_msg);
         check_val("eng_addrcnt", eng_addrcnt, exp_ac);
      end
      check_val("rsp_valid", rsp_valid, exp_rsp_v);
      if (exp_rsp_v) begin
         check_val("rsp_id", rsp_id, exp_rsp_id);
         check_val("rsp_digest", rsp_digest, exp_dig);
      end
      if (rsp_valid && rsp_id == 2'd2) rsp2_cnt++;
      check_val("outstanding", outstanding, m_q.size());
      check_val("err_orphan", err_orphan, m_orphan);

      vmask      = (v_mode < 0) ? 4'($urandom()) : 4'(v_mode);
      req_valid  = vmask;
      cfg_enable = en_val;
      for (int r = 0; r < NREQ; r++) begin
         req_message[r] = rnd_line();
         req_addrcnt[r] = rnd64();
      end
      eng_digest = rnd64();
      if (eng_cnt > 0) eng_ready = ($urandom_range(99) < rdy_pct);
      else             eng_ready = orph_ok;
      if (eng_ready && eng_cnt > 0) eng_cnt--;
      #1;
      if (req_ready[2] && req_valid[2]) dut_g2++;

      g = -1;
      if (m_q.size() < MAXO) begin
         for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (m_ptr + off) % NREQ;
            if (g < 0 && vmask[i] && en_val[i]) g = i;
         end
      end
      check_val("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);

      exp_rsp_v = 1'b0;
      if (eng_ready) begin
         if (m_q.size() > 0) begin
            exp_rsp_v  = 1'b1;
            exp_rsp_id = m_q.pop_front();
            exp_dig    = eng_digest;
         end else begin
            m_orphan = 1'b1;
         end
      end
      exp_eng_req = 1'b0;
      if (g >= 0) begin
         exp_eng_req = 1'b1;
         exp_msg     = req_message[g];
         exp_ac      = req_addrcnt[g];
         m_q.push_back(g);
         m_ptr = (g + 1) % NREQ;
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = 4'hF;
      cfg_enable = 4'hF;
      eng_ready  = 1'b0;
      #1;
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_eng_req", eng_req, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_outstanding", outstanding, 0);
      check_val("rst_err_orphan", err_orphan, 0);
      check_val("rst_eng_message", eng_message, 0);
      check_val("rst_rsp_id", rsp_id, 0);
      check_val("rst_rsp_digest", rsp_digest, 0);
      repeat (2) @(posedge clk);
      #1;
      req_valid  = 4'h0;
      cfg_enable = 4'h0;
      m_q.delete();
      m_ptr       = 0;
      m_orphan    = 1'b0;
      exp_eng_req = 1'b0;
      exp_rsp_v   = 1'b0;
      eng_cnt     = 0;
      rst_n       = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();

      // orphan result while idle: sticky flag, no response
      v_mode = 0; en_val = 4'hF; rdy_pct = 0; orph_ok = 1'b1;
      step();
      orph_ok = 1'b0;
      repeat (3) step();
      check_val("orphan_sticky", err_orphan, 1);
      do_reset();

      // lone job from requester 0
      v_mode = 1; step();
      v_mode = 0; rdy_pct = 50;
      repeat (10) step();

      // everyone valid, engine stalled until the scheduler fills up
      v_mode = 15; rdy_pct = 0;
      repeat (12) step();
      check_val("full_outstanding", outstanding, 8);
      check_val("full_ready", req_ready, 0);
      rdy_pct = 100; step();
      rdy_pct = 0; repeat (3) step();
      check_val("one_more_outstanding", outstanding, 8);

      // requester 2 masked off while its earlier jobs drain
      dut_g2 = 0; rsp2_cnt = 0;
      en_val = 4'b1011; v_mode = -1; rdy_pct = 40;
      repeat (150) step();
      check_val("no_grant_2", dut_g2, 0);
      check_val("rsp2_returned", (rsp2_cnt != 0), 1);

      // mixed random traffic with a reset in the middle
      for (int c = 0; c < 6; c++) begin
         if (c == 3) do_reset();
         en_val  = 4'($urandom());
         rdy_pct = $urandom_range(90, 20);
         repeat (80) step();
      end

      // drain
      v_mode = 0; rdy_pct = 100;
      repeat (20) step();
      check_val("drain_outstanding", outstanding, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/sentry_hash_sched.md
SENTRY_HASH_SCHED -- requirements
Module: sentry_hash_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the hash engine (2..8).
REQ-002 SHALL have parameter MAX_OUTST, default 8, meaning the maximum number of in-flight engine jobs (power of 2).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, reset; reset is asynchronous and active-low.
REQ-005 SHALL have port cfg_enable, input, NREQ, per-requester grant mask (1 = eligible).
REQ-006 SHALL have port req_valid, input, NREQ, per-requester job request.
REQ-007 SHALL have port req_ready, output, NREQ, per-requester accept (one-hot or zero).
REQ-008 SHALL have port req_message, input, NREQ x `LINE_WIDTH, per-requester cache line.
REQ-009 SHALL have port req_addrcnt, input, NREQ x `ADDRCNT_WIDTH, per-requester address/counter.
REQ-010 SHALL have port eng_req, output, 1, single-cycle issue pulse to the pipelined hash engine.
REQ-011 SHALL have port eng_message, output, `LINE_WIDTH, the issued line.
REQ-012 SHALL have port eng_addrcnt, output, `ADDRCNT_WIDTH, the issued address/counter.
REQ-013 SHALL have port eng_ready, input, 1, engine result-valid pulse, in issue order.
REQ-014 SHALL have port eng_digest, input, `SMAC_WIDTH, engine result.
REQ-015 SHALL have port rsp_valid, output, 1, result pulse to the requesters.
REQ-016 SHALL have port rsp_id, output, $clog2(NREQ), owner of rsp_digest.
REQ-017 SHALL have port rsp_digest, output, `SMAC_WIDTH, the returned digest.
REQ-018 SHALL have port outstanding, output, $clog2(MAX_OUTST)+1, count of in-flight jobs.
REQ-019 SHALL have port err_orphan, output, 1, sticky flag set by eng_ready while no job is in flight.

Function
REQ-020 Arbitration SHALL be round-robin over eligible requesters (req_valid & cfg_enable), starting search at last grant + 1, with index 0 first after reset.
REQ-021 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; at most one transfer per cycle.
REQ-022 req_ready SHALL be combinational from the current arbitration and SHALL be all-zero while outstanding == MAX_OUTST.
REQ-023 On a transfer, eng_req SHALL pulse in the next cycle with the message/addrcnt registered from the granted requester (1-cycle issue latency).
REQ-024 Each issue SHALL push the requester index into an ID FIFO of depth MAX_OUTST; outstanding increments by 1.
REQ-025 On eng_ready with a non-empty FIFO, the head index SHALL be popped, and rsp_valid/rsp_id/rsp_digest SHALL be registered out in the next cycle; outstanding decrements by 1.
REQ-026 Simultaneous issue and retire in one cycle SHALL leave outstanding unchanged and keep FIFO order correct.
REQ-027 The full check SHALL count the issue stage, so that an accepted job never overflows the FIFO.
REQ-028 eng_ready while the FIFO is empty SHALL set err_orphan, produce no rsp_valid, and leave the FIFO unchanged.
REQ-029 Deasserting cfg_enable[i] SHALL block new grants to i only; in-flight jobs of i still return.
REQ-030 The FIFO pointers SHALL wrap modulo MAX_OUTST; outstanding SHALL never exceed MAX_OUTST.

Reset
REQ-031 While rst_n is low: req_ready=0, eng_req=0, rsp_valid=0, outstanding=0, err_orphan=0, FIFO empty, RR pointer=0; eng_message, eng_addrcnt, rsp_digest and rsp_id=0.
REQ-032 Reset mid-operation SHALL drop all in-flight IDs; the engine SHALL share rst_n (inverted) so that no stale eng_ready follows.

Structure
REQ-033 LINE_WIDTH, ADDRCNT_WIDTH and SMAC_WIDTH SHALL come from the shared parameters header; the sentry package SHALL hold a requester-ID typedef.
REQ-034 The ID FIFO SHALL be a sub-module named sentry_id_fifo (push, pop, full, empty, count).

Verification
REQ-035 Single requester 0 sends one job: eng_req 1 cycle after handshake; rsp_valid with rsp_id=0 and digest=eng_digest 1 cycle after eng_ready.
REQ-036 All 4 requesters valid continuously: grant order is 0,1,2,3,0,...; each response rsp_id matches issue order.
REQ-037 Engine ready withheld: after 8 accepts req_ready=0 and outstanding=8; one eng_ready then allows exactly one new accept.
REQ-038 Issue and retire in the same cycle at outstanding=5: outstanding stays 5; 20 mixed jobs return with correct IDs.
REQ-039 eng_ready pulse at reset idle: err_orphan=1 (sticky), rsp_valid=0; rst_n low clears it.
REQ-040 cfg_enable=4'b1011 with all valid: requester 2 is never granted; its earlier in-flight job still returns with rsp_id=2.
